// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer: state encoding,
// datapath widths, program base addresses and watchdog limit.
package prog_seq_pkg;

  localparam int PC_W       = 10;
  localparam int CNT_W      = 16;
  localparam int NUM_PROGS  = 3;
  localparam int PROG0_BASE = 0;
  localparam int PROG1_BASE = 96;
  localparam int PROG2_BASE = 256;
  localparam int PROG3_BASE = 512;
  localparam int WATCHDOG   = 1000;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    LAUNCH,
    RUN,
    DONE
  } seq_state_t;

  // Bases wider than the PC are truncated to PC_W bits.
  function automatic logic [PC_W-1:0] base_addr(input logic [1:0] idx);
    logic [PC_W-1:0] b;
    case (idx)
      2'd0:    b = PC_W'(PROG0_BASE);
      2'd1:    b = PC_W'(PROG1_BASE);
      2'd2:    b = PC_W'(PROG2_BASE);
      default: b = PC_W'(PROG3_BASE);
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Launches a series of programs on the fetch unit, forwards branch requests
// while running, and stops fetch on halt or watchdog expiry.
//
//   state  | meaning
//   IDLE   | after reset, fetch frozen, waiting for Start
//   ARMED  | Start seen, waiting for its release
//   LAUNCH | one cycle: jump fetch to the current program base
//   RUN    | program executing, branches forwarded, cycles counted
//   DONE   | program ended by halt or watchdog, results held
module prog_sequencer
  import prog_seq_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             BrTaken,
  input  logic             BrAbsOrRel,
  input  logic [PC_W-1:0]  BrTarget,
  output logic             FetchHold,
  output logic             FetchJump,
  output logic             FetchAbsOrRel,
  output logic [PC_W-1:0]  FetchTarget,
  output logic             Running,
  output logic             Done,
  output logic             Timeout,
  output logic [1:0]       ProgIdx,
  output logic [CNT_W-1:0] CycleCount
);

  seq_state_t state, state_n;
  logic       cnt_clr, cnt_en;
  logic       halt_stop, wd_stop, next_prog;
  logic       wd_hit;

  assign wd_hit  = (CycleCount == CNT_W'(WATCHDOG - 1));
  assign Running = (state == RUN);

  always_comb begin
    state_n       = state;
    FetchHold     = 1'b1;
    FetchJump     = 1'b0;
    FetchAbsOrRel = 1'b0;
    FetchTarget   = '0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    halt_stop     = 1'b0;
    wd_stop       = 1'b0;
    next_prog     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_n = ARMED;
      end
      ARMED: begin
        if (!Start) state_n = LAUNCH;
      end
      LAUNCH: begin
        FetchHold   = 1'b0;
        FetchJump   = 1'b1;
        FetchTarget = base_addr(ProgIdx);
        cnt_clr     = 1'b1;
        state_n     = RUN;
      end
      RUN: begin
        FetchHold     = 1'b0;
        FetchJump     = BrTaken;
        FetchAbsOrRel = BrAbsOrRel;
        FetchTarget   = BrTarget;
        cnt_en        = 1'b1;
        // Halt wins over both a branch and the watchdog in the same cycle.
        if (Halt) begin
          FetchHold = 1'b1;
          FetchJump = 1'b0;
          halt_stop = 1'b1;
          state_n   = DONE;
        end else if (wd_hit) begin
          FetchHold = 1'b1;
          FetchJump = 1'b0;
          cnt_en    = 1'b0;
          wd_stop   = 1'b1;
          state_n   = DONE;
        end
      end
      DONE: begin
        if (Start) begin
          next_prog = 1'b1;
          state_n   = ARMED;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      ProgIdx <= '0;
      Done    <= 1'b0;
      Timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (cnt_clr) begin
        Done    <= 1'b0;
        Timeout <= 1'b0;
      end
      if (halt_stop || wd_stop) Done <= 1'b1;
      if (wd_stop) Timeout <= 1'b1;
      if (next_prog) begin
        Done    <= 1'b0;
        ProgIdx <= (ProgIdx == 2'(NUM_PROGS - 1)) ? 2'd0 : ProgIdx + 2'd1;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (CycleCount)
  );

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a small fetch-unit PC model.
module tb_prog_sequencer;
  import prog_seq_pkg::*;

  logic             Clk = 1'b0;
  logic             Reset, Start, Halt, BrTaken, BrAbsOrRel;
  logic [PC_W-1:0]  BrTarget;
  logic             FetchHold, FetchJump, FetchAbsOrRel;
  logic [PC_W-1:0]  FetchTarget;
  logic             Running, Done, Timeout;
  logic [1:0]       ProgIdx;
  logic [CNT_W-1:0] CycleCount;
  logic [PC_W-1:0]  pc;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic            halt, br, rel;
    logic [PC_W-1:0] tgt;
    logic            e_hold, e_jump, e_rel;
    logic [PC_W-1:0] e_tgt;
    logic            full;
  } vec_t;

  vec_t tbl[5];

  prog_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
    .BrTaken(BrTaken), .BrAbsOrRel(BrAbsOrRel), .BrTarget(BrTarget),
    .FetchHold(FetchHold), .FetchJump(FetchJump),
    .FetchAbsOrRel(FetchAbsOrRel), .FetchTarget(FetchTarget),
    .Running(Running), .Done(Done), .Timeout(Timeout),
    .ProgIdx(ProgIdx), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  // Fetch unit: hold freezes, jump loads absolute or adds relative, else +1.
  always @(posedge Clk) begin
    if (Reset) pc <= '0;
    else if (!FetchHold) begin
      if (FetchJump) pc <= FetchAbsOrRel ? pc + FetchTarget : FetchTarget;
      else           pc <= pc + 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hold"},  32'(FetchHold), 1);
    chk({tag, "_jump"},  32'(FetchJump), 0);
    chk({tag, "_rel"},   32'(FetchAbsOrRel), 0);
    chk({tag, "_tgt"},   32'(FetchTarget), 0);
    chk({tag, "_run"},   32'(Running), 0);
    chk({tag, "_done"},  32'(Done), 0);
    chk({tag, "_tmo"},   32'(Timeout), 0);
    chk({tag, "_idx"},   32'(ProgIdx), 0);
    chk({tag, "_cnt"},   32'(CycleCount), 0);
  endtask

  // From IDLE/DONE: Start pulse, ARMED, LAUNCH, ending in RUN cycle 1.
  task automatic start_pulse(input int exp_idx, input int exp_base);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    mid();
    chk("armed_idx",  32'(ProgIdx), 32'(exp_idx));
    chk("armed_done", 32'(Done), 0);
    chk("armed_hold", 32'(FetchHold), 1);
    tick();
    mid();
    chk("launch_jump", 32'(FetchJump), 1);
    chk("launch_hold", 32'(FetchHold), 0);
    chk("launch_rel",  32'(FetchAbsOrRel), 0);
    chk("launch_tgt",  32'(FetchTarget), 32'(exp_base));
    tick();
    mid();
    chk("run1_running", 32'(Running), 1);
    chk("run1_pc",      32'(pc), 32'(exp_base));
    chk("run1_cnt",     32'(CycleCount), 0);
    chk("run1_tmo",     32'(Timeout), 0);
  endtask

  initial begin
    //           halt br   rel  tgt   hold jump rel  tgt  full
    tbl[0] = '{1'b0, 1'b0, 1'b0, 10'd7,    1'b0, 1'b0, 1'b0, 10'd7,    1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 10'd5,    1'b0, 1'b1, 1'b1, 10'd5,    1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 10'd300,  1'b0, 1'b1, 1'b0, 10'd300,  1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 10'd1023, 1'b0, 1'b0, 1'b1, 10'd1023, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 10'd5,    1'b1, 1'b0, 1'b0, 10'd0,    1'b0};

    Reset = 1'b1; Start = 1'b0; Halt = 1'b0;
    BrTaken = 1'b0; BrAbsOrRel = 1'b0; BrTarget = '0;
    tick();
    tick();
    mid();
    chk_reset("reset");

    // Start held three cycles, then released.
    Reset = 1'b0;
    Start = 1'b1;
    mid();
    chk("idle_hold", 32'(FetchHold), 1);
    tick(); tick(); tick();
    Start = 1'b0;
    mid();
    chk("armed_hold0", 32'(FetchHold), 1);
    chk("armed_jump0", 32'(FetchJump), 0);
    chk("armed_run0",  32'(Running), 0);
    tick();
    mid();
    chk("launch0_jump", 32'(FetchJump), 1);
    chk("launch0_tgt",  32'(FetchTarget), 0);
    chk("launch0_hold", 32'(FetchHold), 0);
    chk("launch0_run",  32'(Running), 0);
    tick();

    // Program 0: halt on the 20th RUN cycle.
    for (int k = 1; k <= 19; k++) begin
      mid();
      chk("p0_running", 32'(Running), 1);
      if (k <= 3) chk("p0_pc", 32'(pc), 32'(k - 1));
      tick();
    end
    Halt = 1'b1;
    mid();
    chk("p0_halt_hold", 32'(FetchHold), 1);
    chk("p0_halt_jump", 32'(FetchJump), 0);
    chk("p0_halt_pc",   32'(pc), 19);
    tick();
    Halt = 1'b0;
    mid();
    chk("p0_done",    32'(Done), 1);
    chk("p0_cnt",     32'(CycleCount), 20);
    chk("p0_tmo",     32'(Timeout), 0);
    chk("p0_running", 32'(Running), 0);
    chk("p0_hold",    32'(FetchHold), 1);
    tick();
    mid();
    chk("p0_pc_frozen",  32'(pc), 19);
    chk("p0_done_held",  32'(Done), 1);
    chk("p0_cnt_frozen", 32'(CycleCount), 20);
    tick();

    // Program 1: branch pass-through vectors, halt on the last row.
    start_pulse(1, 96);
    tick();
    for (int i = 0; i < 5; i++) begin
      Halt = tbl[i].halt; BrTaken = tbl[i].br;
      BrAbsOrRel = tbl[i].rel; BrTarget = tbl[i].tgt;
      mid();
      chk($sformatf("vec%0d_hold", i), 32'(FetchHold), 32'(tbl[i].e_hold));
      chk($sformatf("vec%0d_jump", i), 32'(FetchJump), 32'(tbl[i].e_jump));
      if (tbl[i].full) begin
        chk($sformatf("vec%0d_rel", i), 32'(FetchAbsOrRel), 32'(tbl[i].e_rel));
        chk($sformatf("vec%0d_tgt", i), 32'(FetchTarget), 32'(tbl[i].e_tgt));
      end
      tick();
    end
    Halt = 1'b0; BrTaken = 1'b0; BrAbsOrRel = 1'b0; BrTarget = '0;
    mid();
    chk("p1_done", 32'(Done), 1);
    chk("p1_cnt",  32'(CycleCount), 6);
    chk("p1_pc",   32'(pc), 301);
    tick();

    // Program 2: Start during RUN ignored, then watchdog expiry.
    start_pulse(2, 256);
    tick();
    Start = 1'b1;
    mid();
    chk("p2_start_run", 32'(Running), 1);
    chk("p2_start_hold", 32'(FetchHold), 0);
    tick();
    Start = 1'b0;
    mid();
    chk("p2_still_run", 32'(Running), 1);
    chk("p2_idx",       32'(ProgIdx), 2);
    chk("p2_cnt3",      32'(CycleCount), 2);
    for (int k = 0; k < 997; k++) tick();
    mid();
    chk("wd_cnt",      32'(CycleCount), 999);
    chk("wd_hold",     32'(FetchHold), 1);
    chk("wd_jump",     32'(FetchJump), 0);
    chk("wd_running",  32'(Running), 1);
    tick();
    mid();
    chk("wd_done",    32'(Done), 1);
    chk("wd_tmo",     32'(Timeout), 1);
    chk("wd_cnt_end", 32'(CycleCount), 999);
    chk("wd_run_off", 32'(Running), 0);
    tick();
    mid();
    chk("wd_cnt_frozen", 32'(CycleCount), 999);
    chk("wd_tmo_held",   32'(Timeout), 1);
    tick();

    // Fourth start wraps to program 0; halt coincides with the watchdog cycle.
    start_pulse(0, 0);
    for (int k = 0; k < 999; k++) tick();
    Halt = 1'b1;
    mid();
    chk("wdh_cnt",  32'(CycleCount), 999);
    chk("wdh_hold", 32'(FetchHold), 1);
    tick();
    Halt = 1'b0;
    mid();
    chk("wdh_done", 32'(Done), 1);
    chk("wdh_tmo",  32'(Timeout), 0);
    tick();

    // Program 1: immediate halt.
    start_pulse(1, 96);
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    mid();
    chk("p1b_done", 32'(Done), 1);
    chk("p1b_cnt",  32'(CycleCount), 1);
    tick();

    // Program 2: Start during LAUNCH ignored, then reset mid-RUN.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    Start = 1'b1;
    mid();
    chk("p2b_launch_tgt", 32'(FetchTarget), 256);
    tick();
    Start = 1'b0;
    mid();
    chk("p2b_run", 32'(Running), 1);
    chk("p2b_pc",  32'(pc), 256);
    tick(); tick(); tick(); tick();
    mid();
    chk("p2b_cnt", 32'(CycleCount), 4);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    mid();
    chk_reset("midreset");
    tick();
    mid();
    chk("post_reset_hold", 32'(FetchHold), 1);
    chk("post_reset_run",  32'(Running), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Top-level controller that sequences the instruction-fetch program counter across a series of programs. It drives the fetch unit's hold, jump, abs/rel and target inputs, and launches each program at its base address on a Start handshake. It merges datapath branch requests during execution, stops fetch on Halt, and reports Done, per-program cycle count and watchdog timeout to the testbench. It sits between the decoder/branch logic and the fetch unit.

Parameters:
PC_W, 10, program counter / target width
CNT_W, 16, cycle counter width
NUM_PROGS, 3, number of programs run in series (1..4)
PROG0_BASE, 0, start address of program 0
PROG1_BASE, 96, start address of program 1
PROG2_BASE, 256, start address of program 2
PROG3_BASE, 512, start address of program 3
WATCHDOG, 1000, maximum RUN cycles before forced stop

Ports:
Clk  in  1  clock; all state changes on rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  testbench start request (level, held ≥1 cycle)
Halt  in  1  decoder: current instruction is halt
BrTaken  in  1  branch unit: take branch this cycle
BrAbsOrRel  in  1  0 = absolute, 1 = PC-relative
BrTarget  in  PC_W  branch target / offset
FetchHold  out  1  to fetch Start input: freeze PC
FetchJump  out  1  to fetch Jump
FetchAbsOrRel  out  1  to fetch BranchAbsOrRel
FetchTarget  out  PC_W  to fetch Target
Running  out  1  state == RUN
Done  out  1  program finished; held until next Start
Timeout  out  1  last program ended by watchdog
ProgIdx  out  2  index of current/last program
CycleCount  out  CNT_W  RUN cycles of current/last program

Behaviour:
- Reset (synchronous, active-high; also mid-operation): state IDLE, ProgIdx=0, CycleCount=0, Done=0, Timeout=0, Running=0. Outputs are FetchHold=1, FetchJump=0, FetchAbsOrRel=0, FetchTarget=0.
- States: IDLE, ARMED, LAUNCH, RUN, DONE. Fetch outputs are combinational from state and inputs; all other outputs are registered.
- IDLE: FetchHold=1. Start=1 → ARMED.
- ARMED: FetchHold=1; waits for Start release. Start=0 → LAUNCH.
- LAUNCH (one cycle): FetchHold=0, FetchJump=1, FetchAbsOrRel=0, FetchTarget=base[ProgIdx]. CycleCount clears to 0, Done and Timeout clear. Next state RUN. The PC equals the base address on the first RUN cycle.
- RUN: Running=1, FetchHold=0, and the Br* inputs pass straight through to the Fetch* outputs. CycleCount increments each cycle and saturates at all-ones.
- Halt in RUN (priority over BrTaken in the same cycle): FetchHold=1 and FetchJump=0 combinationally, so the PC freezes on the halt instruction. Next state DONE, Done←1.
- Watchdog: in RUN with CycleCount == WATCHDOG-1 and Halt=0 → DONE, Done←1, Timeout←1, FetchHold=1 that cycle. Halt in the same cycle takes precedence, giving Timeout=0.
- DONE: FetchHold=1, Done=1, CycleCount and Timeout frozen. Start=1 → ARMED, with ProgIdx←ProgIdx+1, wrapping NUM_PROGS-1 → 0, and Done←0.
- Start while in RUN or LAUNCH is ignored.
- Base address outside the PC_W range is truncated to PC_W bits. BrTarget relative arithmetic is done in the fetch unit, not here.

Decomposition:
- Package prog_seq_pkg holds:
  - the state enum seq_state_t {IDLE, ARMED, LAUNCH, RUN, DONE}
  - localparams PC_W and CNT_W
  - a function base_addr(idx) returning the PROGn_BASE value for an index
- One sub-module, sat_counter (CNT_W, with clear, enable and saturate), holds CycleCount.

Test Plan:
1. Reset, Start high 3 cycles then low → ARMED for 3 cycles, one LAUNCH cycle with FetchJump=1 and FetchTarget=0, then RUN with Running=1 and PC advancing 0,1,2…
2. Program 0 runs, Halt asserted on the 20th RUN cycle → the same cycle shows FetchHold=1, FetchJump=0. Next cycle Done=1, CycleCount=20, Timeout=0, PC frozen.
3. From DONE, Start pulse → ProgIdx=1, LAUNCH with FetchTarget=96. A third run launches at 256, and a fourth Start wraps to ProgIdx=0 with FetchTarget=0.
4. In RUN, BrTaken=1, BrAbsOrRel=1, BrTarget=5 → FetchJump=1, FetchAbsOrRel=1, FetchTarget=5 in the same cycle. With Halt=1 also asserted that cycle → FetchJump=0, FetchHold=1.
5. No Halt for 1000 RUN cycles → DONE with Timeout=1, CycleCount=999. A Halt coinciding with cycle 999 gives Timeout=0.
6. Reset asserted mid-RUN of program 2 → next cycle IDLE, ProgIdx=0, Done=0, FetchHold=1. Start pressed during RUN → no state change.
